// File: rtl/arm_pipe_pkg.sv
// Shared ARM pipeline types and constants used by the fetch/decode boundary.
package arm_pipe_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage : arm_pipe_pkg

// File: rtl/fq_storage.sv
// Fetch-queue entry array: one synchronous write port, one asynchronous read port, no reset.
module fq_storage
  import arm_pipe_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ENTRY_W = 2 * WORD_W
) (
  input  logic                     clk,
  input  logic                     wrEn,
  input  logic [$clog2(DEPTH)-1:0] wrIdx,
  input  logic [ENTRY_W-1:0]       wrData,
  input  logic [$clog2(DEPTH)-1:0] rdIdx,
  output logic [ENTRY_W-1:0]       rdData
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrIdx] <= wrData;
    end
  end

  assign rdData = mem[rdIdx];

endmodule : fq_storage

// File: rtl/fetch_queue.sv
// Elastic fetch-to-decode instruction queue: wrap-bit pointers, flush on taken branch.
module fetch_queue
  import arm_pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_pc,
  input  logic [WIDTH-1:0]         in_instr,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_pc,
  output logic [WIDTH-1:0]         out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned PTR_W   = IDX_W + 1;
  localparam int unsigned ENTRY_W = 2 * WIDTH;

  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   rdPtr;
  logic               empty;
  logic               full;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] headEntry;

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[IDX_W-1:0] == rdPtr[IDX_W-1:0]) && (wrPtr[IDX_W] != rdPtr[IDX_W]);

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = wrPtr - rdPtr;

  // Flush drops everything by catching the read pointer up to the write pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (flush) begin
      rdPtr <= wrPtr;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
    end
  end

  fq_storage #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_storage (
    .clk    (clk),
    .wrEn   (push),
    .wrIdx  (wrPtr[IDX_W-1:0]),
    .wrData ({in_pc, in_instr}),
    .rdIdx  (rdPtr[IDX_W-1:0]),
    .rdData (headEntry)
  );

  // An empty queue presents a NOP so decode never sees stale array contents.
  assign out_pc    = empty ? '0 : headEntry[ENTRY_W-1:WIDTH];
  assign out_instr = empty ? WIDTH'(NOP_INSTR) : headEntry[WIDTH-1:0];

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Directed-vector bench for fetch_queue with hand-computed expectations.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic [WIDTH-1:0]       in_pc;
  logic [WIDTH-1:0]       in_instr;
  logic                   in_ready;
  logic                   flush;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_pc;
  logic [WIDTH-1:0]       out_instr;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] count;

  int vecCnt = 0;
  int errCnt = 0;

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chkVec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #12;
    chkVec("rst_out_valid", 64'(out_valid), 64'd0);
    chkVec("rst_out_pc",    64'(out_pc),    64'd0);
    chkVec("rst_out_instr", 64'(out_instr), 64'd0);
    chkVec("rst_count",     64'(count),     64'd0);
    chkVec("rst_in_ready",  64'(in_ready),  64'd1);
    rst = 1'b1;
    step();

    // Fill to full with decode stalled.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'(4 * (i + 1));
      in_instr = 32'hE000_0000 | 32'(i);
      step();
      chkVec("fill_count", 64'(count),     64'(i + 1));
      chkVec("fill_pc",    64'(out_pc),    64'd4);
      chkVec("fill_valid", 64'(out_valid), 64'd1);
    end
    chkVec("full_in_ready", 64'(in_ready), 64'd0);
    in_pc = 32'h99;
    step();
    chkVec("full_push_ignored", 64'(count), 64'd4);

    // Drain in order.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chkVec("drain_pc",    64'(out_pc),    64'(4 * (i + 1)));
      chkVec("drain_instr", 64'(out_instr), 64'(32'hE000_0000 | 32'(i)));
      step();
    end
    chkVec("drained_valid",    64'(out_valid), 64'd0);
    chkVec("drained_instr",    64'(out_instr), 64'd0);
    chkVec("drained_pc",       64'(out_pc),    64'd0);
    chkVec("drained_in_ready", 64'(in_ready),  64'd1);
    chkVec("drained_count",    64'(count),     64'd0);

    // Stream across the pointer wrap.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_pc    = 32'h200 + 32'(4 * i);
      in_instr = 32'hA000_0000 | 32'(i);
      if (i > 0) begin
        chkVec("stream_pc",    64'(out_pc),    64'(32'h200 + 32'(4 * (i - 1))));
        chkVec("stream_instr", 64'(out_instr), 64'(32'hA000_0000 | 32'(i - 1)));
      end
      step();
      chkVec("stream_count", 64'(count), 64'd1);
    end
    out_ready = 1'b0;
    chkVec("stream_last_pc", 64'(out_pc), 64'h224);

    // Grow to three entries, then flush together with a push.
    for (int i = 0; i < 2; i++) begin
      in_pc = 32'h240 + 32'(4 * i);
      step();
    end
    chkVec("preflush_count", 64'(count), 64'd3);
    flush    = 1'b1;
    in_pc    = 32'h100;
    in_instr = 32'h1111_1111;
    step();
    flush    = 1'b0;
    in_valid = 1'b1;
    in_pc    = 32'h300;
    in_instr = 32'h3333_3333;
    chkVec("flush_count",    64'(count),     64'd0);
    chkVec("flush_valid",    64'(out_valid), 64'd0);
    chkVec("flush_in_ready", 64'(in_ready),  64'd1);
    step();
    in_valid = 1'b0;
    chkVec("postflush_pc",    64'(out_pc),    64'h300);
    chkVec("postflush_instr", 64'(out_instr), 64'h3333_3333);
    chkVec("postflush_count", 64'(count),     64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chkVec("postflush_empty", 64'(out_valid), 64'd0);

    // Asynchronous reset with two entries held.
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_pc = 32'h380 + 32'(4 * i);
      step();
    end
    in_valid = 1'b0;
    chkVec("prereset_count", 64'(count), 64'd2);
    #2 rst = 1'b0;
    #1;
    chkVec("async_rst_valid",    64'(out_valid), 64'd0);
    chkVec("async_rst_count",    64'(count),     64'd0);
    chkVec("async_rst_in_ready", 64'(in_ready),  64'd1);
    chkVec("async_rst_pc",       64'(out_pc),    64'd0);
    #1 rst = 1'b1;

    // First edge after release accepts a push; fill to full.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_pc    = 32'h400 + 32'(4 * i);
      in_instr = 32'hB000_0000 | 32'(i);
      step();
      if (i == 0) begin
        chkVec("release_count", 64'(count),  64'd1);
        chkVec("release_pc",    64'(out_pc), 64'h400);
      end
    end
    chkVec("full2_count",    64'(count),    64'd4);
    chkVec("full2_in_ready", 64'(in_ready), 64'd0);

    // Full with concurrent push and pop: only the pop happens.
    in_pc     = 32'h500;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chkVec("fullpp_count",    64'(count),    64'd3);
    chkVec("fullpp_in_ready", 64'(in_ready), 64'd1);
    for (int i = 1; i < 4; i++) begin
      chkVec("fullpp_drain_pc", 64'(out_pc), 64'(32'h400 + 32'(4 * i)));
      step();
    end
    chkVec("fullpp_empty", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule : tb_fetch_queue

// File: doc/fetch_queue.md
# fetch_queue

Elastic instruction queue between the instruction-fetch stage and the decode stage of the ARM pipeline. It holds fetched {PC, instruction} pairs in a small circular FIFO. This decouples decode stalls from fetch. Its full flag becomes the fetch stage's freeze input, and a taken branch flushes every queued entry.

## Interface

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- WIDTH, 32, width of the PC field and of the instruction field.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset; rst=0 clears the queue immediately.
- in_valid  in  1  fetch stage presents a new entry.
- in_pc  in  WIDTH  PC+4 value produced by fetch.
- in_instr  in  WIDTH  fetched instruction word.
- in_ready  out  1  queue can accept an entry this cycle; fetch freeze = ~in_ready.
- flush  in  1  branch taken; discard all entries.
- out_valid  out  1  head entry is valid.
- out_pc  out  WIDTH  PC of the head entry.
- out_instr  out  WIDTH  instruction of the head entry.
- out_ready  in  1  decode consumes the head entry this cycle.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation

- Storage: DEPTH-entry circular buffer with wr_ptr and rd_ptr. Each pointer is $clog2(DEPTH)+1 bits wide; the MSB is a wrap bit.
- Empty: wr_ptr == rd_ptr.
- Full: the index bits are equal and the wrap bits differ.
- count = wr_ptr - rd_ptr, computed modulo 2^($clog2(DEPTH)+1).
- in_ready = ~full. It is a pure function of state and never depends combinationally on out_ready.
- push = in_valid & in_ready & ~flush.
  - Writes in_pc and in_instr at index wr_ptr, then increments wr_ptr.
  - A push offered while full is ignored; the fetch stage is frozen, so it holds its data.
- pop = out_valid & out_ready & ~flush. It increments rd_ptr.
- A push and a pop in the same cycle are both performed, and count is unchanged. This is legal at any fill level except full, because in_ready=0 when full.
- out_valid = ~empty.
  - Non-empty: out_pc and out_instr show the entry at rd_ptr.
  - Empty: both are forced to 0. Decode then sees the encoding 0, which is treated as a NOP.
- Flush is synchronous and overrides everything:
  - at the next edge, rd_ptr is set to wr_ptr's value, so count=0;
  - any push or pop in the flush cycle is discarded.
- The storage array is not cleared by reset or by flush; only the pointers are.

## Timing

- Reset values: out_valid=0, out_pc=0, out_instr=0, count=0, in_ready=1. Both pointers are 0.
- Latency: an entry pushed at edge k is presented at the output in the cycle after edge k. There is no combinational bypass from input to output.
- Throughput: one push and one pop per cycle in steady state.
- Full → pop: in_ready rises in the cycle after the popping edge.
- Flush asserted in cycle k: out_valid=0 and in_ready=1 from edge k+1 onward. A push in cycle k+1 appears at the output in cycle k+2.
- Wrap-around: pointers roll over modulo 2·DEPTH with no bubble; ordering is preserved.
- Reset asserted mid-operation: all outputs go to their reset values asynchronously, without waiting for clk.
- Reset release: the deassertion is synchronised upstream; the first push is accepted on the first edge with rst=1.

## Structure

- Shared package, arm_pipe_pkg:
  - WORD_W=32;
  - NOP_INSTR=32'h0000_0000, used as the empty-output value;
  - the fetch_entry_t record {pc, instr}.
- Sub-module fq_storage: DEPTH×(2·WIDTH) register array with one synchronous write port and one asynchronous read port, no reset.
- fetch_queue itself contains only the pointer and control logic.

## Test plan

- Reset then fill: release rst; push PCs 4, 8, 12, 16 with out_ready=0 → count goes 1→4; in_ready=0 after the 4th edge; out_pc=4 throughout.
- Drain in order: from full, hold out_ready=1 and in_valid=0 → out_pc reads 4, 8, 12, 16 on successive cycles; then out_valid=0, out_instr=0, in_ready=1.
- Streaming across the wrap boundary: run 10 cycles with in_valid=out_ready=1 and incrementing PCs → count stays 1 after the first cycle; the output sequence equals the input sequence delayed by one cycle, across the pointer wrap.
- Flush with simultaneous push: with 3 entries held, assert flush together with in_valid=1 (PC=0x100) → next cycle count=0 and out_valid=0; PC 0x100 never appears at the output.
- Asynchronous reset mid-stream: with 2 entries held, pull rst low between clock edges → out_valid=0 and count=0 before the next edge.
- Full with concurrent push and pop: at count=4 drive in_valid=1 and out_ready=1 → the pop occurs, the push is rejected, count=3, and in_ready=1 in the following cycle.
